myrsp_udp_framer: RTL and testbench
===================================

MYRSP_UDP_FRAMER -- requirements
Module: myrsp_udp_framer

Interface
REQ-001 SHALL have parameter DATA_AW, default 11, meaning log2 of payload store depth in bytes (2048).
REQ-002 SHALL have parameter LEN_AW, default 2, meaning log2 of committed-packet queue depth (4 entries).
REQ-003 SHALL have parameter MAX_LEN, default 1406, meaning the largest accepted packet in bytes; MAX_LEN SHALL be less than 2^DATA_AW.
REQ-004 SHALL have parameters SRC_PORT and DST_PORT, both default 16'd5000, meaning the UDP ports driven on every frame.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have ports s_axis_tdata (in, 8), s_axis_tvalid (in, 1), s_axis_tready (out, 1), s_axis_tlast (in, 1, ignored): myRSP packet bytes.
REQ-008 SHALL have ports s_hdr_valid (in, 1), s_hdr_ready (out, 1), s_hdr_length (in, 16): packet-end commit from packetizer.
REQ-009 SHALL have ports m_udp_hdr_valid (out, 1), m_udp_hdr_ready (in, 1), m_udp_length (out, 16), m_udp_source_port (out, 16), m_udp_dest_port (out, 16): UDP header to the UDP stack.
REQ-010 SHALL have ports m_udp_payload_tdata (out, 8), m_udp_payload_tvalid (out, 1), m_udp_payload_tready (in, 1), m_udp_payload_tlast (out, 1): UDP payload.
REQ-011 SHALL have outputs drop_pulse (1) and mismatch_pulse (1): single-cycle status strobes.

Function
REQ-012 SHALL accept a byte when s_axis_tvalid && s_axis_tready; s_axis_tready = store not full.
REQ-013 SHALL count accepted bytes of the open packet in a 16-bit counter wpkt_cnt; a byte accepted in the same cycle as an s_hdr handshake SHALL belong to the packet being committed.
REQ-014 SHALL drive s_hdr_ready = length queue not full; on s_hdr handshake the packet SHALL be committed with length = counted bytes (including the same-cycle byte), never s_hdr_length.
REQ-015 SHALL pulse mismatch_pulse for one cycle, the cycle after a commit whose s_hdr_length differs from the counted length.
REQ-016 SHALL, once wpkt_cnt reaches MAX_LEN, keep s_axis_tready high (subject to REQ-012) but discard further bytes, and on commit rewind the write pointer to the packet start, push nothing, and pulse drop_pulse the next cycle.
REQ-017 SHALL treat a commit with zero counted bytes as a silent discard: no queue entry, no pulse.
REQ-018 SHALL make a committed packet's bytes and length visible to the read side the cycle after the commit handshake (committed write pointer updates then).
REQ-019 SHALL run the read FSM with states IDLE, HDR, PAYLOAD; reset state IDLE.
REQ-020 IDLE: if the length queue is non-empty, pop it into len_reg and go to HDR next cycle.
REQ-021 HDR: assert m_udp_hdr_valid with m_udp_length = len_reg + 8 (16-bit, no overflow since MAX_LEN < 65528); hold all header outputs stable until m_udp_hdr_ready; then go to PAYLOAD.
REQ-022 PAYLOAD: emit exactly len_reg bytes in store order, valid-then-ready, with data/valid/last held stable while tvalid && !tready; tlast SHALL be high only on byte len_reg; after its handshake return to IDLE.
REQ-023 SHALL use a registered read from the store with one output register, sustaining one byte per cycle while m_udp_payload_tready stays high.
REQ-024 SHALL use DATA_AW+1-bit pointers; full/empty SHALL be decided by MSB-differ/equal compare, with correct wrap of address bits.
REQ-025 m_udp_source_port and m_udp_dest_port SHALL be constant SRC_PORT and DST_PORT.

Reset
REQ-026 SHALL on rst clear all pointers, counters, queue, and FSM to IDLE asynchronously; open or in-flight packets are lost.
REQ-027 SHALL hold during reset: s_axis_tready=0, s_hdr_ready=0, m_udp_hdr_valid=0, m_udp_length=0, m_udp_payload_tvalid=0, m_udp_payload_tlast=0, m_udp_payload_tdata=0, drop_pulse=0, mismatch_pulse=0.

Verification
REQ-028 Bytes 0x00..0x09, then hdr length 10, sinks always ready -> one header with m_udp_length=18, ports 5000/5000, then 10 bytes 0x00..0x09 with tlast on 0x09 only.
REQ-029 Two 300-byte packets, payload tready random 50% -> 600 bytes out in order, no loss or duplication, tlast on bytes 300 and 600.
REQ-030 m_udp_hdr_ready=0, five 16-byte commits -> s_hdr_ready low after the fourth commit is queued and the read FSM has popped one; release -> five frames in order.
REQ-031 Packet of MAX_LEN+5 bytes then commit, then 20-byte packet -> drop_pulse once, no frame for the first, one 28-length frame for the second.
REQ-032 12 bytes with s_hdr_length=18 -> mismatch_pulse once, frame m_udp_length=20; zero-byte commit -> no frame, no pulse.
REQ-033 rst asserted mid-PAYLOAD -> all outputs per REQ-027 immediately; after release a fresh 10-byte packet frames correctly.

Source files
------------

// File: rtl/myrsp_udp_framer.sv
// myRSP -> UDP framer: buffers packet bytes until committed, then
// emits a UDP header followed by the stored payload.
module myrsp_udp_framer #(
  parameter int          DATA_AW  = 11,
  parameter int          LEN_AW   = 2,
  parameter int          MAX_LEN  = 1406,
  parameter logic [15:0] SRC_PORT = 16'd5000,
  parameter logic [15:0] DST_PORT = 16'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_hdr_valid,
  output logic        s_hdr_ready,
  input  logic [15:0] s_hdr_length,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [7:0]  m_udp_payload_tdata,
  output logic        m_udp_payload_tvalid,
  input  logic        m_udp_payload_tready,
  output logic        m_udp_payload_tlast,
  output logic        drop_pulse,
  output logic        mismatch_pulse
);

  localparam int          PW   = DATA_AW + 1;
  localparam int          LW   = LEN_AW + 1;
  localparam logic [15:0] MAXL = 16'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  logic [7:0]    mem [2**DATA_AW];
  logic [15:0]   lq  [2**LEN_AW];
  logic [PW-1:0] wptr, wcmt, rptr;
  logic [LW-1:0] lq_w, lq_r;
  logic [15:0]   wpkt_cnt, len_reg, rd_left, cnt_tot;
  logic          ovf, ovf_tot;
  logic          full, lq_full, lq_empty;
  logic          byte_acc, byte_wr, under_max;
  logic          commit, push, drop;
  logic          pop, hdr_hs, pay_hs, load;
  logic          unused_tlast;
  state_t        state, state_nx;

  assign unused_tlast = s_axis_tlast;

  assign full = (wptr[DATA_AW] != rptr[DATA_AW]) &&
                (wptr[DATA_AW-1:0] == rptr[DATA_AW-1:0]);
  assign lq_full = (lq_w[LEN_AW] != lq_r[LEN_AW]) &&
                   (lq_w[LEN_AW-1:0] == lq_r[LEN_AW-1:0]);
  assign lq_empty = (lq_w == lq_r);

  assign s_axis_tready = !rst && !full;
  assign s_hdr_ready   = !rst && !lq_full;

  // Bytes past MAX_LEN are accepted but never stored; the packet is dropped.
  assign byte_acc  = s_axis_tvalid && s_axis_tready;
  assign under_max = (wpkt_cnt < MAXL);
  assign byte_wr   = byte_acc && under_max;
  assign commit    = s_hdr_valid && s_hdr_ready;
  assign cnt_tot   = wpkt_cnt + 16'(byte_wr);
  assign ovf_tot   = ovf || (byte_acc && !under_max);
  assign push      = commit && !ovf_tot && (cnt_tot != 16'd0);
  assign drop      = commit && ovf_tot;

  always_ff @(posedge clk) begin
    if (byte_wr) mem[wptr[DATA_AW-1:0]] <= s_axis_tdata;
    if (push)    lq[lq_w[LEN_AW-1:0]]   <= cnt_tot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr           <= '0;
      wcmt           <= '0;
      wpkt_cnt       <= '0;
      ovf            <= 1'b0;
      lq_w           <= '0;
      drop_pulse     <= 1'b0;
      mismatch_pulse <= 1'b0;
    end else begin
      drop_pulse     <= drop;
      mismatch_pulse <= push && (s_hdr_length != cnt_tot);
      if (commit) begin
        wpkt_cnt <= '0;
        ovf      <= 1'b0;
        if (drop) begin
          wptr <= wcmt;
        end else begin
          wptr <= wptr + PW'(byte_wr);
          wcmt <= wptr + PW'(byte_wr);
        end
      end else begin
        wptr     <= wptr + PW'(byte_wr);
        wpkt_cnt <= cnt_tot;
        ovf      <= ovf_tot;
      end
      if (push) lq_w <= lq_w + LW'(1);
    end
  end

  assign pop    = (state == IDLE) && !lq_empty;
  assign hdr_hs = (state == HDR) && m_udp_hdr_ready;
  assign pay_hs = m_udp_payload_tvalid && m_udp_payload_tready;
  assign load   = (state == PAYLOAD) && (rd_left != 16'd0) &&
                  (!m_udp_payload_tvalid || m_udp_payload_tready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!lq_empty) state_nx = HDR;
      HDR:     if (m_udp_hdr_ready) state_nx = PAYLOAD;
      PAYLOAD: if (pay_hs && m_udp_payload_tlast) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Store read lands straight in the output register, one byte per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg              <= '0;
      rd_left              <= '0;
      rptr                 <= '0;
      lq_r                 <= '0;
      m_udp_payload_tdata  <= '0;
      m_udp_payload_tvalid <= 1'b0;
      m_udp_payload_tlast  <= 1'b0;
    end else begin
      if (pop) begin
        len_reg <= lq[lq_r[LEN_AW-1:0]];
        lq_r    <= lq_r + LW'(1);
      end
      if (hdr_hs) rd_left <= len_reg;
      if (load) begin
        m_udp_payload_tdata  <= mem[rptr[DATA_AW-1:0]];
        m_udp_payload_tvalid <= 1'b1;
        m_udp_payload_tlast  <= (rd_left == 16'd1);
        rptr                 <= rptr + PW'(1);
        rd_left              <= rd_left - 16'd1;
      end else if (pay_hs) begin
        m_udp_payload_tvalid <= 1'b0;
        m_udp_payload_tlast  <= 1'b0;
      end
    end
  end

  assign m_udp_hdr_valid   = (state == HDR);
  assign m_udp_length      = (state == HDR) ? len_reg + 16'd8 : 16'd0;
  assign m_udp_source_port = SRC_PORT;
  assign m_udp_dest_port   = DST_PORT;

endmodule

// File: tb/tb_myrsp_udp_framer.sv
// Directed bench for myrsp_udp_framer: framing, back-pressure,
// oversize drop, length mismatch and mid-frame reset.
module tb_myrsp_udp_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_hdr_valid = 1'b0;
  logic        s_hdr_ready;
  logic [15:0] s_hdr_length = '0;
  logic        m_udp_hdr_valid;
  logic        m_udp_hdr_ready = 1'b1;
  logic [15:0] m_udp_length;
  logic [15:0] m_udp_source_port;
  logic [15:0] m_udp_dest_port;
  logic [7:0]  m_udp_payload_tdata;
  logic        m_udp_payload_tvalid;
  logic        m_udp_payload_tready = 1'b1;
  logic        m_udp_payload_tlast;
  logic        drop_pulse;
  logic        mismatch_pulse;

  myrsp_udp_framer dut (
    .clk                  (clk),
    .rst                  (rst),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tlast         (s_axis_tlast),
    .s_hdr_valid          (s_hdr_valid),
    .s_hdr_ready          (s_hdr_ready),
    .s_hdr_length         (s_hdr_length),
    .m_udp_hdr_valid      (m_udp_hdr_valid),
    .m_udp_hdr_ready      (m_udp_hdr_ready),
    .m_udp_length         (m_udp_length),
    .m_udp_source_port    (m_udp_source_port),
    .m_udp_dest_port      (m_udp_dest_port),
    .m_udp_payload_tdata  (m_udp_payload_tdata),
    .m_udp_payload_tvalid (m_udp_payload_tvalid),
    .m_udp_payload_tready (m_udp_payload_tready),
    .m_udp_payload_tlast  (m_udp_payload_tlast),
    .drop_pulse           (drop_pulse),
    .mismatch_pulse       (mismatch_pulse)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  int         hq[$];
  logic [8:0] pq[$];
  int         drop_cnt = 0;
  int         mm_cnt = 0;
  bit         rnd = 1'b0;
  logic       prev_pv = 1'b0, prev_pr = 1'b0;
  logic       prev_hv = 1'b0, prev_hr = 1'b0;
  logic [8:0] prev_pd = '0;
  logic [15:0] prev_hl = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1 m_udp_payload_tready = rnd ? 1'($urandom % 2) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_pv = 1'b0;
      prev_hv = 1'b0;
    end else begin
      if (prev_pv && !prev_pr)
        check("pay_hold", 32'({m_udp_payload_tvalid, m_udp_payload_tlast,
                                m_udp_payload_tdata}), 32'({1'b1, prev_pd}));
      if (prev_hv && !prev_hr)
        check("hdr_hold", 32'({m_udp_hdr_valid, m_udp_length}),
              32'({1'b1, prev_hl}));
      if (m_udp_hdr_valid && m_udp_hdr_ready) begin
        hq.push_back(int'(m_udp_length));
        check("src_port", 32'(m_udp_source_port), 32'd5000);
        check("dst_port", 32'(m_udp_dest_port), 32'd5000);
      end
      if (m_udp_payload_tvalid && m_udp_payload_tready)
        pq.push_back({m_udp_payload_tlast, m_udp_payload_tdata});
      if (drop_pulse) drop_cnt++;
      if (mismatch_pulse) mm_cnt++;
      prev_pv = m_udp_payload_tvalid;
      prev_pr = m_udp_payload_tready;
      prev_pd = {m_udp_payload_tlast, m_udp_payload_tdata};
      prev_hv = m_udp_hdr_valid;
      prev_hr = m_udp_hdr_ready;
      prev_hl = m_udp_length;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hs_wait(input bit need_hdr);
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if ((!s_axis_tvalid || s_axis_tready) && (!need_hdr || s_hdr_ready)) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check("hs_timeout", 32'd0, 32'd1);
  endtask

  // Last byte travels in the same cycle as its commit.
  task automatic pkt(input int n, input int base, input int hl);
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = 8'(base + i);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == n - 1);
      if (i == n - 1) begin
        s_hdr_valid  = 1'b1;
        s_hdr_length = 16'(hl);
      end
      hs_wait(i == n - 1);
    end
    if (n == 0) begin
      s_hdr_valid  = 1'b1;
      s_hdr_length = 16'(hl);
      hs_wait(1'b1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_hdr_valid   = 1'b0;
  endtask

  task automatic wait_out(input int nb, input int nh);
    int t = 0;
    while ((pq.size() < nb || hq.size() < nh) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("out_timeout", 32'(t < 20000), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int len, input int base);
    logic [8:0] e, g;
    if (hq.size() < 1 || pq.size() < len) begin
      check({tag, "_avail"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_len"}, 32'(hq.pop_front()), 32'(len + 8));
    for (int i = 0; i < len; i++) begin
      e = {(i == len - 1), 8'(base + i)};
      g = pq.pop_front();
      check($sformatf("%s_b%0d", tag, i), 32'(g), 32'(e));
    end
  endtask

  task automatic check_rst_outs(input string tag);
    check({tag, "_flags"},
          32'({s_axis_tready, s_hdr_ready, m_udp_hdr_valid,
               m_udp_payload_tvalid, m_udp_payload_tlast,
               drop_pulse, mismatch_pulse}), 32'd0);
    check({tag, "_len"}, 32'(m_udp_length), 32'd0);
    check({tag, "_data"}, 32'(m_udp_payload_tdata), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, m0;
    idle(3);
    check_rst_outs("reset");
    rst = 1'b0;
    idle(2);
    check("ready_after_rst", 32'({s_axis_tready, s_hdr_ready}), 32'd3);

    pkt(10, 0, 10);
    wait_out(10, 1);
    idle(10);
    check("t1_extra", 32'(hq.size() + pq.size()), 32'd11);
    check_frame("t1", 10, 0);

    rnd = 1'b1;
    pkt(300, 'h10, 300);
    pkt(300, 'h80, 300);
    wait_out(600, 2);
    rnd = 1'b0;
    idle(10);
    check("t2_count", 32'(pq.size()), 32'd600);
    check_frame("t2a", 300, 'h10);
    check_frame("t2b", 300, 'h80);

    m_udp_hdr_ready = 1'b0;
    for (int k = 0; k < 5; k++) pkt(16, 'h20 + 16 * k, 16);
    check("t3_hdr_full", 32'(s_hdr_ready), 32'd0);
    check("t3_hdr_valid", 32'(m_udp_hdr_valid), 32'd1);
    idle(5);
    m_udp_hdr_ready = 1'b1;
    wait_out(80, 5);
    idle(10);
    for (int k = 0; k < 5; k++)
      check_frame($sformatf("t3f%0d", k), 16, 'h20 + 16 * k);

    d0 = drop_cnt;
    pkt(1411, 0, 1411);
    pkt(20, 'h40, 20);
    wait_out(20, 1);
    idle(10);
    check("t4_drop", 32'(drop_cnt - d0), 32'd1);
    check("t4_nhdr", 32'(hq.size()), 32'd1);
    check_frame("t4", 20, 'h40);

    m0 = mm_cnt;
    pkt(12, 'h50, 18);
    wait_out(12, 1);
    idle(5);
    check("t5_mm", 32'(mm_cnt - m0), 32'd1);
    check_frame("t5", 12, 'h50);
    d0 = drop_cnt;
    m0 = mm_cnt;
    pkt(0, 0, 0);
    idle(20);
    check("t5_zero_out", 32'(hq.size() + pq.size()), 32'd0);
    check("t5_zero_pulse", 32'((drop_cnt - d0) + (mm_cnt - m0)), 32'd0);

    pkt(200, 0, 200);
    wait_out(5, 1);
    #2 rst = 1'b1;
    #1 check_rst_outs("t6_rst");
    idle(2);
    check_rst_outs("t6_hold");
    rst = 1'b0;
    hq.delete();
    pq.delete();
    pkt(10, 'h90, 10);
    wait_out(10, 1);
    idle(10);
    check("t6_count", 32'(hq.size() + pq.size()), 32'd11);
    check_frame("t6", 10, 'h90);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
